// File: rtl/ads1292_sample_to_float.sv
// ads1292_sample_to_float: exact 24-bit two's-complement ADC sample to IEEE-754 single conversion.
// Optional DC offset subtraction with saturation when ADS1292_OFFSET_SUB_EN is defined. Rev 1.0
`default_nettype none

module ads1292_sample_to_float #(
  parameter logic signed [23:0] OFFSET = 24'sh000000
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [23:0] i_ADC_DATA,
  input  logic        i_ADC_DATA_VALID,
  output logic        o_ADC_DATA_READY,
  output logic [31:0] o_X_DATA,
  output logic        o_X_DATA_VALID,
  input  logic        i_X_DATA_READY,
  output logic        o_SAT
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ABS    = 3'd1,
    ST_NORM   = 3'd2,
    ST_PACK   = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [23:0] sample;
  logic [23:0] mag;
  logic        sign;
  logic [4:0]  k;
  logic        ready_q;
  logic        valid_q;
  logic [31:0] x_q;

  logic        accept;
  logic [23:0] operand;
  logic        clamped;
  logic        operand_sign;
  logic [23:0] operand_mag;

  assign accept = i_ADC_DATA_VALID && ready_q;

`ifdef ADS1292_OFFSET_SUB_EN
  logic [24:0] diff;
  logic        sat_q;

  // Bits 24 and 23 disagree exactly when the 25-bit difference leaves the 24-bit range.
  always_comb begin
    diff    = {sample[23], sample} - {OFFSET[23], OFFSET};
    operand = diff[23:0];
    clamped = 1'b0;
    if (!diff[24] && diff[23]) begin
      operand = 24'h7FFFFF;
      clamped = 1'b1;
    end else if (diff[24] && !diff[23]) begin
      operand = 24'h800000;
      clamped = 1'b1;
    end
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sat_q <= 1'b0;
    end else if (state == ST_ABS) begin
      sat_q <= clamped;
    end
  end

  assign o_SAT = sat_q;
`else
  logic unused_offset;

  assign operand       = sample;
  assign clamped       = 1'b0;
  assign unused_offset = ^{OFFSET, clamped};
  assign o_SAT         = 1'b0;
`endif

  // Negating 0x800000 wraps back to 0x800000, which is the correct magnitude.
  assign operand_sign = operand[23];
  assign operand_mag  = operand_sign ? (~operand + 24'd1) : operand;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:   state_nxt = accept ? ST_ABS : ST_IDLE;
      ST_ABS:    state_nxt = (operand_mag == 24'd0) ? ST_PACK : ST_NORM;
      ST_NORM:   state_nxt = (mag[23] || (k == 5'd23)) ? ST_PACK : ST_NORM;
      ST_PACK:   state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = i_X_DATA_READY ? ST_IDLE : ST_FINISH;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      sample  <= 24'd0;
      mag     <= 24'd0;
      sign    <= 1'b0;
      k       <= 5'd0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      x_q     <= 32'd0;
    end else begin
      ready_q <= (state_nxt == ST_IDLE);
      valid_q <= (state_nxt == ST_FINISH);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            sample <= i_ADC_DATA;
          end
        end
        ST_ABS: begin
          sign <= operand_sign;
          mag  <= operand_mag;
          k    <= 5'd0;
        end
        ST_NORM: begin
          if (!mag[23] && (k != 5'd23)) begin
            mag <= {mag[22:0], 1'b0};
            k   <= k + 5'd1;
          end
        end
        ST_PACK: begin
          if (mag == 24'd0) begin
            x_q <= 32'h0000_0000;
          end else begin
            x_q <= {sign, 8'd150 - {3'b000, k}, mag[22:0]};
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_ADC_DATA_READY = ready_q;
  assign o_X_DATA_VALID   = valid_q;
  assign o_X_DATA         = x_q;

endmodule

`default_nettype wire
